// File: rtl/move_sequencer_if.sv
// move_sequencer_if: request, merge-unit and result signals of the move sequencer
interface move_sequencer_if #(parameter int TILE_W = 4);
  logic req_p, req_ai, gnt_p, gnt_ai, line_valid, busy, done, changed;
  logic [2:0] dir_p, dir_ai;
  logic [16*TILE_W-1:0] board_in, board_out;
  logic [4*TILE_W-1:0] line_out, line_res;
  modport master(
    output req_p, dir_p, req_ai, dir_ai, board_in, line_res,
    input gnt_p, gnt_ai, line_out, line_valid, busy, done, board_out, changed
  );
  modport slave(
    input req_p, dir_p, req_ai, dir_ai, board_in, line_res,
    output gnt_p, gnt_ai, line_out, line_valid, busy, done, board_out, changed
  );
endinterface

// File: rtl/move_sequencer.sv
// move_sequencer: runs one 2048 move through a shared line-merge unit, one line per cycle
module move_sequencer #(
  parameter int TILE_W = 4,
  parameter bit RR_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  move_sequencer_if.slave m
);
  localparam int BW = 16 * TILE_W;
  localparam int LW = 4 * TILE_W;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [BW-1:0] lat, work, nxt;
  logic [LW-1:0] line;
  logic [2:0] dir;
  logic [1:0] k;
  logic ptr, vp, va, gp, ga, vert, rev;
  assign vp = m.req_p && m.dir_p != 3'd0 && m.dir_p <= 3'd4;
  assign va = m.req_ai && m.dir_ai != 3'd0 && m.dir_ai <= 3'd4;
  // ptr set means the player won last, so the AI is favoured next
  assign gp = state == IDLE && vp && (!va || !RR_EN || !ptr);
  assign ga = state == IDLE && va && !gp;
  assign m.gnt_p = gp;
  assign m.gnt_ai = ga;
  assign vert = dir == 3'd1 || dir == 3'd2;
  assign rev = dir == 3'd2 || dir == 3'd4;
  assign m.line_out = m.line_valid ? line : '0;
  always_comb begin
    int jj, r, c, base;
    line = '0;
    nxt = work;
    jj = 0;
    r = 0;
    c = 0;
    base = 0;
    for (int j = 0; j < 4; j++) begin
      jj = rev ? 3 - j : j;
      r = vert ? jj : int'(k);
      c = vert ? int'(k) : jj;
      base = (15 - (4 * r + c)) * TILE_W;
      line[j*TILE_W +: TILE_W] = lat[base +: TILE_W];
      nxt[base +: TILE_W] = m.line_res[j*TILE_W +: TILE_W];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= 1'b0;
      lat <= '0;
      work <= '0;
      dir <= '0;
      k <= '0;
      m.busy <= 1'b0;
      m.done <= 1'b0;
      m.line_valid <= 1'b0;
      m.board_out <= '0;
      m.changed <= 1'b0;
    end else begin
      m.done <= 1'b0;
      case (state)
        IDLE: if (gp || ga) begin
          ptr <= gp;
          lat <= m.board_in;
          dir <= gp ? m.dir_p : m.dir_ai;
          work <= '0;
          k <= '0;
          m.busy <= 1'b1;
          m.line_valid <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          work <= nxt;
          k <= k + 2'd1;
          if (k == 2'd3) begin
            m.line_valid <= 1'b0;
            m.board_out <= nxt;
            m.changed <= nxt != lat;
            m.done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          m.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed checks of move sequencing, arbitration and reset abort
module tb_move_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] k1;
  move_sequencer_if #(.TILE_W(4)) a ();
  move_sequencer_if #(.TILE_W(4)) b ();
  move_sequencer #(.TILE_W(4), .RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .m(a));
  move_sequencer #(.TILE_W(4), .RR_EN(1'b0)) dut_fx (.clk(clk), .rst(rst), .m(b));
  always #5 clk = ~clk;
  function automatic logic [15:0] merge(input logic [15:0] l);
    logic [3:0] t [4];
    logic [3:0] o [4];
    int n, i, q;
    logic [15:0] r;
    for (int j = 0; j < 4; j++) begin
      t[j] = 4'd0;
      o[j] = 4'd0;
    end
    n = 0;
    for (int j = 0; j < 4; j++)
      if (l[j*4 +: 4] != 4'd0) begin
        t[n] = l[j*4 +: 4];
        n++;
      end
    i = 0;
    q = 0;
    while (i < n) begin
      if (i + 1 < n && t[i] == t[i+1]) begin
        o[q] = t[i] + 4'd1;
        i += 2;
      end else begin
        o[q] = t[i];
        i++;
      end
      q++;
    end
    r = {o[3], o[2], o[1], o[0]};
    return r;
  endfunction
  assign a.line_res = merge(a.line_out);
  assign b.line_res = merge(b.line_out);
  assign b.req_p = a.req_p;
  assign b.dir_p = a.dir_p;
  assign b.req_ai = a.req_ai;
  assign b.dir_ai = a.dir_ai;
  assign b.board_in = a.board_in;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_move(input bit ai, input logic [2:0] d, input logic [63:0] bd,
                         input logic [63:0] ex, input logic exch);
    if (ai) begin
      a.req_ai = 1'b1;
      a.dir_ai = d;
    end else begin
      a.req_p = 1'b1;
      a.dir_p = d;
    end
    a.board_in = bd;
    #1;
    chk(ai ? "gnt_ai" : "gnt_p", ai ? a.gnt_ai : a.gnt_p, 1'b1);
    tick();
    a.req_p = 1'b0;
    a.req_ai = 1'b0;
    a.board_in = ~bd;
    for (int i = 1; i <= 4; i++) begin
      chk("run_valid", {a.line_valid, a.busy, a.done}, 3'b110);
      if (i == 2) k1 = a.line_out;
      tick();
    end
    chk("done_pulse", {a.done, a.busy, a.line_valid, a.line_out}, {3'b110, 16'h0});
    chk("board_out", a.board_out, ex);
    chk("changed", a.changed, exch);
    tick();
    chk("after_done", {a.done, a.busy}, 2'b00);
    chk("board_hold", a.board_out, ex);
  endtask
  initial begin
    a.req_p = 1'b0;
    a.req_ai = 1'b0;
    a.dir_p = 3'd0;
    a.dir_ai = 3'd0;
    a.board_in = '0;
    repeat (3) tick();
    chk("rst_outs", {a.busy, a.done, a.line_valid, a.changed, a.gnt_p, a.gnt_ai}, 6'b0);
    chk("rst_line", a.line_out, 16'h0);
    chk("rst_board", a.board_out, 64'h0);
    rst = 1'b1;
    tick();
    do_move(1'b0, 3'd4, 64'h0000_0100_0000_0010, 64'h0000_0001_0000_0001, 1'b1);
    do_move(1'b0, 3'd1, 64'h0000_0100_0000_0010, 64'h0110_0000_0000_0000, 1'b1);
    chk("up_k1_line", k1, 16'h0010);
    do_move(1'b0, 3'd4, 64'h0000_0000_0000_1111, 64'h0000_0000_0000_0022, 1'b1);
    do_move(1'b0, 3'd3, 64'h1000_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    a.req_p = 1'b1;
    a.dir_p = 3'd3;
    a.req_ai = 1'b1;
    a.dir_ai = 3'd1;
    a.board_in = '0;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("rr_gnt", {a.gnt_p, a.gnt_ai}, (g == 1) ? 2'b01 : 2'b10);
      chk("fix_gnt", {b.gnt_p, b.gnt_ai}, 2'b10);
      tick();
      for (int i = 1; i <= 5; i++) begin
        chk("busy_nogrant", {a.busy, a.gnt_p, a.gnt_ai, b.busy, b.gnt_p, b.gnt_ai}, 6'b100100);
        tick();
      end
    end
    a.req_p = 1'b0;
    a.req_ai = 1'b1;
    a.dir_ai = 3'd0;
    #1;
    chk("dir0_gnt", a.gnt_ai, 1'b0);
    tick();
    chk("dir0_idle", a.busy, 1'b0);
    a.dir_ai = 3'd7;
    #1;
    chk("dir7_gnt", a.gnt_ai, 1'b0);
    tick();
    chk("dir7_idle", a.busy, 1'b0);
    do_move(1'b1, 3'd2, 64'h0000_0100_0000_0010, 64'h0000_0000_0000_0110, 1'b1);
    a.req_p = 1'b1;
    a.dir_p = 3'd4;
    a.board_in = 64'h0000_0100_0000_0010;
    #1;
    chk("abort_gnt", a.gnt_p, 1'b1);
    tick();
    a.req_p = 1'b0;
    tick();
    tick();
    chk("abort_k2", {a.busy, a.line_valid}, 2'b11);
    rst = 1'b0;
    tick();
    chk("abort_outs", {a.busy, a.done, a.line_valid, a.changed, a.gnt_p, a.gnt_ai}, 6'b0);
    chk("abort_line", a.line_out, 16'h0);
    chk("abort_board", a.board_out, 64'h0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("abort_nodone", {a.done, a.busy}, 2'b00);
      tick();
    end
    do_move(1'b0, 3'd4, 64'h0000_0100_0000_0010, 64'h0000_0001_0000_0001, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
